// File: rtl/pipeline_dmem_responder.sv
// Data-memory responder for the MEM stage of the pipelined MIPS core.
// Serves one word-aligned load or store at a time after a programmable
// latency and raises MemStall so the hazard unit freezes the pipeline
// until the access completes.
`timescale 1ns/1ps

module pipeline_dmem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemError,
    output logic        MemStall
);

    localparam int         DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [3:0] LOAD_COUNT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_count;
    logic [31:0]             r_addr;
    logic [31:0]             r_wdata;
    logic                    r_isRead;
    logic                    r_isWrite;
    logic [31:0]             r_readData;
    logic                    r_memReady;
    logic                    r_memError;
    logic [31:0]             r_mem [DEPTH];

    logic                    w_req;
    logic                    w_misaligned;
    logic                    w_outOfRange;
    logic                    w_conflict;
    logic                    w_error;
    logic [ADDR_WIDTH-1:0]   w_index;

    // Request decode and error classification of the latched access
    assign w_req        = MemRead | MemWrite;
    assign w_misaligned = (r_addr[1:0] != 2'b00);
    assign w_outOfRange = ((r_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    assign w_conflict   = r_isRead & r_isWrite;
    assign w_error      = w_misaligned | w_outOfRange | w_conflict;
    assign w_index      = r_addr[ADDR_WIDTH+1:2];

    // Stall only looks at the current request and the registered ready,
    // so there is no combinational path back through the hazard unit
    assign MemStall = w_req & ~r_memReady;
    assign ReadData = r_readData;
    assign MemReady = r_memReady;
    assign MemError = r_memError;

    // Responder FSM: latch request, count down latency, access, pulse ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_count    <= 4'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_isRead   <= 1'b0;
            r_isWrite  <= 1'b0;
            r_readData <= 32'd0;
            r_memReady <= 1'b0;
            r_memError <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_memReady <= 1'b0;
                    if (w_req) begin
                        r_addr    <= Address;
                        r_wdata   <= WriteData;
                        r_isRead  <= MemRead;
                        r_isWrite <= MemWrite;
                        r_count   <= LOAD_COUNT;
                        r_state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!w_req) begin
                        r_state <= ST_IDLE;
                    end else if (r_count != 4'd0) begin
                        r_count <= r_count - 4'd1;
                    end else begin
                        if (w_error) begin
                            r_readData <= 32'd0;
                            r_memError <= 1'b1;
                        end else if (r_isWrite) begin
                            r_mem[w_index] <= r_wdata;
                            r_readData     <= 32'd0;
                            r_memError     <= 1'b0;
                        end else begin
                            r_readData <= r_mem[w_index];
                            r_memError <= 1'b0;
                        end
                        r_memReady <= 1'b1;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_memReady <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_memReady <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
